player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
- Front-end stage between the raw board pushbuttons (btnU/btnD/btnL/btnR/btnS) and the bomberman game-state logic.
- Synchronises and debounces each button, then converts presses into one-shot move and bomb-drop commands.
- Delivers commands over two valid/ready channels, with optional hold-to-repeat for movement.
- Enforces a bomb-drop cooldown so a held or bouncing btnS cannot flood the bomb logic.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable cycles required before a debounced level changes (1..2^20-1)
BOMB_COOLDOWN, 100000, cycles after an accepted bomb command during which btnS presses are ignored (0 disables)
REPEAT_DELAY, 200000, cycles a direction must be held before the first auto-repeat (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 100000, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_raw  in  5  raw buttons {S,U,D,L,R}, bit4=S ... bit0=R, asynchronous to clk
game_en  in  1  game running (sw-derived); low flushes and suppresses all commands
move_valid  out  1  move command pending
move_dir  out  2  00=up 01=down 10=left 11=right, stable while move_valid
move_ready  in  1  game logic accepts move
bomb_valid  out  1  bomb-drop command pending
bomb_ready  in  1  game logic accepts bomb
btn_db  out  5  debounced button levels (for display/debug)

Behaviour:
- Reset (async assert, sync deassert handled upstream): all synchroniser flops, btn_db, counters = 0; move_valid=0, move_dir=00, bomb_valid=0; move FSM = IDLE; cooldown = 0.
- Sync: 2-flop synchroniser per bit. Debounce: per-bit counter, cleared whenever sync level == btn_db bit. Otherwise it increments; on reaching DEBOUNCE_CYCLES, btn_db bit flips and the counter clears. Latency from clean edge to btn_db: 2+DEBOUNCE_CYCLES cycles.
- Press = rising edge of btn_db bit (registered previous value).
- Direction priority on simultaneous presses in the same cycle: U > D > L > R; lower-priority presses in that cycle are discarded.
- Move channel, single-entry slot:
  - A press while move_valid=0 loads move_dir and sets move_valid on the next cycle.
  - A press while move_valid=1 and move_ready=0 is dropped; no overwrite.
  - Handshake completes when move_valid & move_ready; move_valid clears the next cycle unless a new press lands in that same cycle, in which case the slot reloads (back-to-back).
- Move FSM: IDLE -> HELD on an accepted direction press (latches held_dir). HELD -> IDLE when btn_db[held_dir] falls. Other directions pressed while HELD are handled as normal presses and do not change held_dir.
- Bomb channel:
  - A btnS press with cooldown==0 and bomb_valid==0 sets bomb_valid.
  - On the handshake, bomb_valid clears and cooldown loads BOMB_COOLDOWN, then decrements to 0.
  - Presses during cooldown or while pending are dropped.
  - Holding btnS produces exactly one command.
- Simultaneous btnS and a direction press: both channels fire independently in the same cycle.
- game_en=0: move_valid, bomb_valid, FSM and cooldown are forced to reset values each cycle. Debounce keeps running. Presses are ignored; a button already held when game_en rises generates no command until it is released and re-pressed.
- Reset mid-handshake: valid drops immediately (async); the game logic must treat this as no transfer.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - FSM adds REPEAT state. In HELD, a counter runs; when it reaches REPEAT_DELAY, the FSM enters REPEAT and issues a move of held_dir.
  - In REPEAT, a move of held_dir is issued every REPEAT_PERIOD cycles.
  - A repeat issued while the slot is full is dropped, and the period counter restarts.
  - Releasing held_dir returns the FSM to IDLE from either state.
- Undefined: no repeat logic or counters; one command per press.

Decomposition:
- Package player_input_pkg: dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), button bit-index constants (BTN_R=0..BTN_S=4), move FSM state enum.
- One sub-module btn_debounce (single bit: synchroniser + counter + level output, parameter DEBOUNCE_CYCLES), instantiated 5 times.

Test Plan:
(DEBOUNCE_CYCLES=4, BOMB_COOLDOWN=20, REPEAT_DELAY=30, REPEAT_PERIOD=10; move_ready/bomb_ready tied 1 unless stated)
- Bounce: toggle btnD 1/0 every 2 cycles for 12 cycles, then hold 1 -> exactly one move_valid with move_dir=01, asserted 2+4+1 cycles after the final rising edge; none during bouncing.
- Priority/backpressure: move_ready=0; press U and R in the same cycle -> move_dir=00 held. Press L while pending -> dropped. Raise move_ready -> one transfer, no L.
- Bomb cooldown: hold btnS for 100 cycles -> one bomb transfer. Release, then re-press 10 cycles after the accept -> ignored. Re-press 25 cycles after the accept -> second bomb.
- game_en: hold btnL, raise game_en -> no command. Release and re-press -> one move, dir=10. Drop game_en while move_valid=1 (ready=0) -> move_valid=0 next cycle.
- Reset: assert rst_n=0 mid-cooldown with bomb_valid=1 -> all outputs 0 immediately. After release, a btnS press is accepted without waiting for the old cooldown.
- AUTO_REPEAT_EN: hold btnR for 70 stable cycles -> moves at accept+0, +30, +40, +50, +60. Release -> no further moves. Without the macro -> exactly one move.

Source files
------------

// File: rtl/player_input_pkg.sv
// Shared types and constants for the player input front-end.
package player_input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Bit positions inside btn_raw / btn_db ({S,U,D,L,R}).
  localparam int BTN_R   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_U   = 3;
  localparam int BTN_S   = 4;
  localparam int NUM_BTN = 5;

  typedef enum logic [1:0] {
    MV_IDLE   = 2'd0,
    MV_HELD   = 2'd1,
    MV_REPEAT = 2'd2
  } move_state_t;

  // Direction code to its button bit: UP->3, DOWN->2, LEFT->1, RIGHT->0.
  function automatic logic [2:0] dir_to_btn(input dir_t d);
    return 3'd3 - {1'b0, d};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit synchroniser plus stability counter. The output level only
// changes after the synchronised input differs from it for DEBOUNCE_CYCLES
// consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic [19:0] cnt;

  // Two-flop synchroniser for the asynchronous pushbutton.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count cycles of disagreement; flip the level once it has persisted long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync2 == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      btn_db <= ~btn_db;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Pushbutton front-end for the game logic: debounces the five buttons and turns
// presses into one-shot move / bomb commands on two valid/ready channels.
// Define AUTO_REPEAT_EN to add hold-to-repeat for movement.
//
// state     | meaning
// MV_IDLE   | no direction being tracked
// MV_HELD   | direction accepted, waiting for release (or first repeat)
// MV_REPEAT | direction held past the initial delay, repeating periodically
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned BOMB_COOLDOWN   = 100000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 200000,
  parameter int unsigned REPEAT_PERIOD   = 100000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic       game_en,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       bomb_valid,
  input  logic       bomb_ready,
  output logic [4:0] btn_db
);

  logic [4:0]  btn_prev;
  logic [4:0]  press;
  logic        dir_press;
  dir_t        dir_sel;
  logic        repeat_fire;
  logic        slot_free;
  logic        load_move;
  dir_t        new_dir;
  move_state_t state, state_nxt;
  dir_t        held_dir, held_dir_nxt;
  logic [31:0] cooldown;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .btn_db  (btn_db[i])
    );
  end

  // Previous debounced levels for rising-edge (press) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev <= '0;
    else        btn_prev <= btn_db;
  end

  assign press = btn_db & ~btn_prev;

  // Pick one direction per cycle: U > D > L > R, the rest are discarded.
  always_comb begin
    dir_press = 1'b1;
    dir_sel   = DIR_UP;
    if      (press[BTN_U]) dir_sel = DIR_UP;
    else if (press[BTN_D]) dir_sel = DIR_DOWN;
    else if (press[BTN_L]) dir_sel = DIR_LEFT;
    else if (press[BTN_R]) dir_sel = DIR_RIGHT;
    else                   dir_press = 1'b0;
  end

  // A fresh press beats a simultaneous auto-repeat.
  assign slot_free = ~move_valid | move_ready;
  assign new_dir   = dir_press ? dir_sel : held_dir;
  assign load_move = game_en & (dir_press | repeat_fire) & slot_free;

`ifdef AUTO_REPEAT_EN
  logic [31:0] rpt_cnt, rpt_cnt_nxt;

  // Move FSM state, held direction and repeat down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MV_IDLE;
      held_dir <= DIR_UP;
      rpt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      held_dir <= held_dir_nxt;
      rpt_cnt  <= rpt_cnt_nxt;
    end
  end

  // Next state; release takes precedence over a repeat due in the same cycle.
  always_comb begin
    state_nxt    = state;
    held_dir_nxt = held_dir;
    rpt_cnt_nxt  = rpt_cnt;
    repeat_fire  = 1'b0;
    if (!game_en) begin
      state_nxt   = MV_IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        MV_IDLE: begin
          if (dir_press && slot_free) begin
            state_nxt    = MV_HELD;
            held_dir_nxt = dir_sel;
            rpt_cnt_nxt  = REPEAT_DELAY - 1;
          end
        end
        MV_HELD, MV_REPEAT: begin
          if (!btn_db[dir_to_btn(held_dir)]) begin
            state_nxt = MV_IDLE;
          end else if (rpt_cnt == '0) begin
            repeat_fire = 1'b1;
            state_nxt   = MV_REPEAT;
            rpt_cnt_nxt = REPEAT_PERIOD - 1;
          end else begin
            rpt_cnt_nxt = rpt_cnt - 32'd1;
          end
        end
        default: state_nxt = MV_IDLE;
      endcase
    end
  end
`else
  assign repeat_fire = 1'b0;

  // Move FSM state and held direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MV_IDLE;
      held_dir <= DIR_UP;
    end else begin
      state    <= state_nxt;
      held_dir <= held_dir_nxt;
    end
  end

  // Next state: track the accepted direction until it is released.
  always_comb begin
    state_nxt    = state;
    held_dir_nxt = held_dir;
    if (!game_en) begin
      state_nxt = MV_IDLE;
    end else begin
      case (state)
        MV_IDLE: begin
          if (dir_press && slot_free) begin
            state_nxt    = MV_HELD;
            held_dir_nxt = dir_sel;
          end
        end
        MV_HELD: begin
          if (!btn_db[dir_to_btn(held_dir)]) state_nxt = MV_IDLE;
        end
        default: state_nxt = MV_IDLE;
      endcase
    end
  end
`endif

  // Single-entry move slot; reloads back-to-back when a press lands on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
    end else if (!game_en) begin
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
    end else if (load_move) begin
      move_valid <= 1'b1;
      move_dir   <= new_dir;
    end else if (move_ready) begin
      move_valid <= 1'b0;
    end
  end

  // Bomb slot with post-accept cooldown; presses while pending or cooling are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bomb_valid <= 1'b0;
      cooldown   <= '0;
    end else if (!game_en) begin
      bomb_valid <= 1'b0;
      cooldown   <= '0;
    end else if (bomb_valid && bomb_ready) begin
      bomb_valid <= 1'b0;
      cooldown   <= BOMB_COOLDOWN;
    end else begin
      if (press[BTN_S] && (cooldown == '0) && !bomb_valid) bomb_valid <= 1'b1;
      if (cooldown != '0) cooldown <= cooldown - 32'd1;
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: each stimulus pushes the expected
// transfers (direction and cycle), a negedge monitor pops and compares them.
module tb_player_input_ctrl;
  import player_input_pkg::*;

  localparam int DB = 4;
  localparam int LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic       game_en = 1'b1;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready = 1'b1;
  logic       bomb_valid;
  logic       bomb_ready = 1'b1;
  logic [4:0] btn_db;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .BOMB_COOLDOWN   (20)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (30),
    .REPEAT_PERIOD   (10)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .game_en    (game_en),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .bomb_valid (bomb_valid),
    .bomb_ready (bomb_ready),
    .btn_db     (btn_db)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dir;
    logic [31:0] cyc;
  } mv_t;

  mv_t exp_move[$];
  int  exp_bomb[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  n_move_exp = 0;
  int  n_move_obs = 0;
  int  n_bomb_exp = 0;
  int  n_bomb_obs = 0;
  mv_t m;
  int  b;
  int  c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_move(input logic [1:0] d, input int at);
    exp_move.push_back('{dir: d, cyc: 32'(at)});
    n_move_exp++;
  endtask

  task automatic push_bomb(input int at);
    exp_bomb.push_back(at);
    n_bomb_exp++;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_moves"}, n_move_obs, n_move_exp);
    chk({tag, "_bombs"}, n_bomb_obs, n_bomb_exp);
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (move_valid && move_ready) begin
        n_move_obs++;
        if (exp_move.size() > 0) begin
          m = exp_move.pop_front();
          chk("move_dir", move_dir, m.dir);
          chk("move_cyc", cyc, m.cyc);
        end
      end
      if (bomb_valid && bomb_ready) begin
        n_bomb_obs++;
        if (exp_bomb.size() > 0) begin
          b = exp_bomb.pop_front();
          chk("bomb_cyc", cyc, b);
        end
      end
    end
  end

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_move_dir", move_dir, 0);
    chk("rst_bomb_valid", bomb_valid, 0);
    chk("rst_btn_db", btn_db, 0);

    // S and U pressed together: both channels fire in the same cycle.
    c = cyc;
    btn_raw = 5'b11000;
    push_move(DIR_UP, c + LAT);
    push_bomb(c + LAT);
    step(15);
    btn_raw = '0;
    step(40);
    chk_counts("both");

    // Bouncing D: nothing until it settles high.
    for (int i = 0; i < 3; i++) begin
      btn_raw = 5'b00100;
      step(2);
      btn_raw = '0;
      step(2);
    end
    btn_raw = 5'b00100;
    c = cyc;
    push_move(DIR_DOWN, c + LAT);
    step(10);
    chk("bounce_btn_db", btn_db, 5'b00100);
    step(5);
    btn_raw = '0;
    step(20);
    chk_counts("bounce");

    // Backpressure with U+R together; a later L is dropped.
    move_ready = 1'b0;
    c = cyc;
    btn_raw = 5'b01001;
    step(10);
    chk("prio_valid", move_valid, 1);
    chk("prio_dir", move_dir, DIR_UP);
    btn_raw = 5'b01011;
    step(12);
    chk("prio_hold_dir", move_dir, DIR_UP);
    step(3);
    move_ready = 1'b1;
    push_move(DIR_UP, cyc);
    step(1);
    btn_raw = '0;
    step(30);
    chk_counts("prio");

    // Held S gives one bomb.
    c = cyc;
    btn_raw = 5'b10000;
    push_bomb(c + LAT);
    step(100);
    btn_raw = '0;
    step(40);
    chk_counts("bomb_hold");

    // Re-press during cooldown is ignored, after cooldown it is accepted.
    c = cyc;
    btn_raw = 5'b10000;
    push_bomb(c + LAT);
    step(8);
    btn_raw = '0;
    step(5);
    btn_raw = 5'b10000;
    step(9);
    btn_raw = '0;
    step(5);
    btn_raw = 5'b10000;
    push_bomb(c + 27 + LAT);
    step(13);
    btn_raw = '0;
    step(40);
    chk_counts("cooldown");

    // L held across game_en rising gives nothing; a fresh press does.
    game_en = 1'b0;
    btn_raw = 5'b00010;
    step(20);
    game_en = 1'b1;
    step(20);
    chk_counts("gen_held");
    btn_raw = '0;
    step(10);
    c = cyc;
    btn_raw = 5'b00010;
    push_move(DIR_LEFT, c + LAT);
    step(12);
    btn_raw = '0;
    step(15);
    move_ready = 1'b0;
    btn_raw = 5'b00100;
    step(10);
    chk("gen_pending", move_valid, 1);
    game_en = 1'b0;
    step(1);
    chk("gen_flush", move_valid, 0);
    btn_raw = '0;
    step(10);
    game_en = 1'b1;
    move_ready = 1'b1;
    step(20);
    chk_counts("gen");

    // Reset during cooldown with a move pending.
    move_ready = 1'b0;
    c = cyc;
    btn_raw = 5'b10000;
    push_bomb(c + LAT);
    step(9);
    btn_raw = 5'b00100;
    step(10);
    chk("pre_rst_move_valid", move_valid, 1);
    #1;
    rst_n = 1'b0;
    btn_raw = '0;
    #1;
    chk("rst_async_move_valid", move_valid, 0);
    chk("rst_async_bomb_valid", bomb_valid, 0);
    chk("rst_async_btn_db", btn_db, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    c = cyc;
    btn_raw = 5'b10000;
    push_bomb(c + LAT);
    step(10);
    btn_raw = '0;
    step(30);
    move_ready = 1'b1;
    step(5);
    chk_counts("reset");

    // Held R: one move, plus periodic repeats when enabled.
    c = cyc;
    btn_raw = 5'b00001;
    push_move(DIR_RIGHT, c + LAT);
`ifdef AUTO_REPEAT_EN
    push_move(DIR_RIGHT, c + LAT + 30);
    push_move(DIR_RIGHT, c + LAT + 40);
    push_move(DIR_RIGHT, c + LAT + 50);
    push_move(DIR_RIGHT, c + LAT + 60);
`endif
    step(65);
    btn_raw = '0;
    step(40);
    chk_counts("repeat");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
